// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: steps an external 4:1 line mux (sel) through start/data/parity/stop.
// Define UART_TX_PARITY_EN to insert one parity bit between the data and stop bits.
module uart_tx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  baud_tick,
    input  logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  parity_odd,
    output logic [1:0]            sel,
    output logic                  start_bit,
    output logic                  stop_bit,
    output logic                  data_bit,
    output logic                  parity_bit,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned      CNT_W     = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_stop_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_accept;
    logic                  w_frame_end;

    // busy doubles as the pending-request flag while the FSM still sits in idle
    assign w_accept    = tx_start && !r_busy;
    assign w_frame_end = baud_tick && (r_state == StStop) && (r_stop_cnt == LAST_STOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (baud_tick) begin
            case (r_state)
                StIdle: begin
                    if (r_busy || tx_start) begin
                        w_state_next = StStart;
                    end
                end
                StStart: w_state_next = StData;
                StData: begin
                    if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = StParity;
`else
                        w_state_next = StStop;
`endif
                    end
                end
                StParity: w_state_next = StStop;
                StStop: begin
                    if (r_stop_cnt == LAST_STOP) begin
                        w_state_next = StIdle;
                    end
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_frame_end;
            if (w_accept) begin
                r_busy  <= 1'b1;
                r_shift <= tx_data;
            end else if (w_frame_end) begin
                r_busy <= 1'b0;
            end
            if (baud_tick) begin
                case (r_state)
                    StStart: r_bit_cnt <= '0;
                    StData: begin
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + CNT_W'(1);
                    end
                    StStop: r_stop_cnt <= (r_stop_cnt == LAST_STOP) ? 1'b0 : 1'b1;
                    default: ;
                endcase
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    logic r_parity;

    // parity is fixed at acceptance so it stays stable for the whole frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= (^tx_data) ^ parity_odd;
        end
    end

    assign parity_bit = r_parity;
`else
    logic w_unused_parity_odd;

    assign w_unused_parity_odd = parity_odd;
    assign parity_bit          = 1'b0;
`endif

    always_comb begin
        sel = 2'b11;
        case (r_state)
            StStart:  sel = 2'b00;
            StData:   sel = 2'b01;
`ifdef UART_TX_PARITY_EN
            StParity: sel = 2'b10;
`endif
            default:  sel = 2'b11;
        endcase
        start_bit = 1'b0;
        stop_bit  = 1'b1;
        data_bit  = r_busy ? r_shift[0] : 1'b1;
        busy      = r_busy;
        done      = r_done;
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomised self-checking bench for uart_tx_ctrl; expected frames come from a bit-list model.
// Builds with parity and STOP_BITS=1 when UART_TX_PARITY_EN is defined, else no parity and STOP_BITS=2.
module tb_uart_tx_ctrl;

    localparam int unsigned DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned SB     = 1;
    localparam int unsigned PAR_EN = 1;
`else
    localparam int unsigned SB     = 2;
    localparam int unsigned PAR_EN = 0;
`endif
    localparam int FRAME_LEN = 1 + DW + PAR_EN + SB;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          baud_tick  = 1'b0;
    logic          tx_start   = 1'b0;
    logic          parity_odd = 1'b0;
    logic [DW-1:0] tx_data    = '0;
    logic [1:0]    sel;
    logic          start_bit;
    logic          stop_bit;
    logic          data_bit;
    logic          parity_bit;
    logic          busy;
    logic          done;

    int n_cmp      = 0;
    int n_bad      = 0;
    int done_seen  = 0;
    int sel10_seen = 0;

    uart_tx_ctrl #(
        .DATA_WIDTH (DW),
        .STOP_BITS  (SB)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_tick  (baud_tick),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .parity_odd (parity_odd),
        .sel        (sel),
        .start_bit  (start_bit),
        .stop_bit   (stop_bit),
        .data_bit   (data_bit),
        .parity_bit (parity_bit),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // baud_tick: one-clk pulse every 16 clk, changed on the falling edge
    initial begin
        int unsigned cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            cnt = (cnt == 15) ? 0 : cnt + 1;
            baud_tick = (cnt == 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done) done_seen++;
            if (sel == 2'b10) sel10_seen++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_parity(input logic [DW-1:0] d, input logic odd);
        if (PAR_EN == 0) return 1'b0;
        return (($countones(d) % 2) == 1) ^ odd;
    endfunction

    // Expected (sel, line) for bit slot i of a frame
    function automatic void frame_elem(input logic [DW-1:0] d, input logic odd, input int i,
                                       output logic [1:0] s, output logic l);
        if (i == 0) begin
            s = 2'b00;
            l = 1'b0;
        end else if (i <= DW) begin
            s = 2'b01;
            l = d[i-1];
        end else if (PAR_EN != 0 && i == DW + 1) begin
            s = 2'b10;
            l = exp_parity(d, odd);
        end else begin
            s = 2'b11;
            l = 1'b1;
        end
    endfunction

    function automatic logic dut_line();
        case (sel)
            2'b00:   return start_bit;
            2'b01:   return data_bit;
            2'b10:   return parity_bit;
            default: return stop_bit;
        endcase
    endfunction

    task automatic wait_tick_edge(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(posedge clk);
            if (baud_tick) ok = 1'b1;
        end
        #1;
    endtask

    task automatic drive_req(input logic [DW-1:0] d, input logic odd);
        tx_start   = 1'b1;
        tx_data    = d;
        parity_odd = odd;
    endtask

    // Follows one frame from the acceptance edge; returns in the done cycle (or after an abort)
    task automatic check_frame(input logic [DW-1:0] d, input logic odd, input bit intrude,
                               input int abort_at);
        bit         tick_now;
        bit         ok;
        logic [1:0] es;
        logic       el;
        int         done0;
        done0 = done_seen;
        @(posedge clk);
        tick_now = baud_tick;
        #1;
        check_eq("accept_busy", busy, 1);
        check_eq("accept_done_low", done, 0);
        if (!tick_now) check_eq("pending_sel", sel, 2'b11);
        tx_start   = 1'b0;
        tx_data    = DW'($urandom);
        parity_odd = 1'($urandom);
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (!(i == 0 && tick_now)) begin
                wait_tick_edge(ok);
                check_eq("tick_timeout", ok, 1);
                if (!ok) return;
            end
            frame_elem(d, odd, i, es, el);
            check_eq($sformatf("sel[%0d]", i), sel, es);
            check_eq($sformatf("line[%0d]", i), dut_line(), el);
            check_eq($sformatf("busy[%0d]", i), busy, 1);
            check_eq($sformatf("parity[%0d]", i), parity_bit, exp_parity(d, odd));
            if (intrude && i == 3) begin
                tx_start   = 1'b1;
                tx_data    = 8'h3C;
                parity_odd = ~odd;
                @(posedge clk);
                #1;
                tx_start = 1'b0;
            end
            if (i == abort_at) begin
                #31;
                rst_n = 1'b0;
                #2;
                check_eq("abort_sel", sel, 2'b11);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_done", done, 0);
                check_eq("abort_data_bit", data_bit, 1);
                check_eq("abort_parity_bit", parity_bit, 0);
                repeat (3) @(negedge clk);
                check_eq("abort_no_done_pulse", done_seen - done0, 0);
                rst_n = 1'b1;
                return;
            end
        end
        wait_tick_edge(ok);
        check_eq("end_tick_timeout", ok, 1);
        check_eq("end_done", done, 1);
        check_eq("end_busy", busy, 0);
        check_eq("end_sel", sel, 2'b11);
        @(negedge clk);
        #1;
        check_eq("done_count", done_seen - done0, 1);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          odd;
        int            guard;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_sel", sel, 2'b11);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_data_bit", data_bit, 1);
        check_eq("rst_parity_bit", parity_bit, 0);
        check_eq("rst_start_bit", start_bit, 0);
        check_eq("rst_stop_bit", stop_bit, 1);
        rst_n = 1'b1;

        // First request right at reset release, then the parity corner patterns
        drive_req(8'hA5, 1'b0);
        check_frame(8'hA5, 1'b0, 1'b0, -1);
        @(posedge clk); #1;
        check_eq("done_width", done, 0);
        drive_req(8'h00, 1'b1);
        check_frame(8'h00, 1'b1, 1'b0, -1);
        drive_req(8'hFF, 1'b1);
        check_frame(8'hFF, 1'b1, 1'b0, -1);
        drive_req(8'h81, 1'b0);
        check_frame(8'h81, 1'b0, 1'b0, -1);

        // Request during a frame must be dropped, not queued
        repeat (7) @(negedge clk);
        drive_req(8'h96, 1'b0);
        check_frame(8'h96, 1'b0, 1'b1, -1);
        repeat (20) @(negedge clk);
        check_eq("intrude_not_queued", busy, 0);

        // Back-to-back: second request raised in the done cycle
        drive_req(8'hC3, 1'b0);
        check_frame(8'hC3, 1'b0, 1'b0, -1);
        drive_req(8'h5A, 1'b1);
        check_frame(8'h5A, 1'b1, 1'b0, -1);
        @(posedge clk); #1;
        check_eq("b2b_done_width", done, 0);

        // Request coinciding with a baud_tick
        guard = 0;
        do begin
            @(negedge clk); #1;
            guard++;
        end while (!baud_tick && guard < 40);
        check_eq("coincide_found_tick", baud_tick, 1);
        drive_req(8'h3C, 1'b1);
        check_frame(8'h3C, 1'b1, 1'b0, -1);

        // Reset during data bit 4, then recovery on the first edge after release
        repeat (5) @(negedge clk);
        drive_req(8'hE7, 1'b0);
        check_frame(8'hE7, 1'b0, 1'b0, 5);
        drive_req(8'h4B, 1'b1);
        check_frame(8'h4B, 1'b1, 1'b0, -1);

        // Random frames at random tick alignment
        for (int k = 0; k < 10; k++) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
            d   = DW'($urandom);
            odd = 1'($urandom);
            drive_req(d, odd);
            check_frame(d, odd, 1'b0, -1);
        end
        @(posedge clk); #1;
        check_eq("final_idle_busy", busy, 0);

`ifndef UART_TX_PARITY_EN
        check_eq("sel_never_10", sel10_seen, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning number of data bits per frame (legal 5..9).
REQ-002 SHALL have parameter STOP_BITS, default 1, meaning number of stop-bit periods per frame (legal 1 or 2).
REQ-003 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port baud_tick, input, 1, one-clk pulse marking each bit-period boundary.
REQ-006 SHALL have port tx_start, input, 1, request to transmit tx_data.
REQ-007 SHALL have port tx_data, input, DATA_WIDTH, frame payload, sampled on acceptance.
REQ-008 SHALL have port parity_odd, input, 1, 0 = even parity, 1 = odd parity, sampled on acceptance.
REQ-009 SHALL have port sel, output, 2, TX mux select: 00 start, 01 data, 10 parity, 11 stop/idle.
REQ-010 SHALL have ports start_bit (constant 0) and stop_bit (constant 1), output, 1 each, mux level inputs.
REQ-011 SHALL have port data_bit, output, 1, current data bit for mux input 01.
REQ-012 SHALL have port parity_bit, output, 1, computed parity for mux input 10.
REQ-013 SHALL have ports busy, output, 1 (frame accepted or in progress), and done, output, 1 (one-clk frame-complete pulse).

Function
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP; sel SHALL be 11 in IDLE and STOP, 00 in START, 01 in DATA, 10 in PARITY.
REQ-015 SHALL accept tx_start only when busy=0; acceptance latches tx_data into a shift register, latches parity_odd, sets busy=1 on the next edge.
REQ-016 SHALL ignore tx_start while busy=1 (no queueing, no corruption of the frame in flight).
REQ-017 SHALL leave IDLE for START only on a baud_tick with a request pending; if tx_start and baud_tick coincide with busy=0, START SHALL be entered on that same edge.
REQ-018 SHALL advance the state and bit counters only on baud_tick; each frame bit therefore lasts exactly one tick period.
REQ-019 SHALL send data LSB first: data_bit = shift_reg[0]; the register shifts right on each baud_tick in DATA; DATA lasts exactly DATA_WIDTH ticks.
REQ-020 SHALL compute parity_bit = XOR of latched data for even, inverted XOR for odd, stable from acceptance to end of frame.
REQ-021 SHALL hold STOP for STOP_BITS ticks, then on the final tick return to IDLE, clear busy, and pulse done high for exactly one clk.
REQ-022 SHALL accept a tx_start asserted in the same cycle done is high (back-to-back frames with no extra idle period beyond tick alignment).
REQ-023 SHALL keep sel=11 while a request is pending but no baud_tick has occurred yet.

Reset
REQ-024 SHALL, on rst_n low, asynchronously force state IDLE, sel=11, busy=0, done=0, data_bit=1, parity_bit=0, counters and shift register 0, pending request cleared.
REQ-025 SHALL, on reset mid-frame, abort the frame immediately (line returns to 11/idle high) and not pulse done.
REQ-026 SHALL leave reset synchronously to clk; the first tx_start SHALL be accepted on the first edge after rst_n deasserts.

Configuration
REQ-027 SHALL, when UART_TX_PARITY_EN is defined, insert PARITY (one tick) between DATA and STOP.
REQ-028 SHALL, when UART_TX_PARITY_EN is undefined, go DATA -> STOP directly, never drive sel=10, tie parity_bit to 0, and ignore parity_odd.

Verification
REQ-029 SHALL verify: parity enabled, baud_tick every 16 clk, tx_start with tx_data=0xA5, parity_odd=0 -> sel/line sequence start 0, data 1,0,1,0,0,1,0,1, parity 0, stop 1; done one pulse; busy high 11 ticks.
REQ-030 SHALL verify: tx_data=0x00, parity_odd=1 -> parity_bit=1 throughout frame; tx_data=0xFF, parity_odd=1 -> parity_bit=1 (8 ones is even, so the odd-parity bit is 1).
REQ-031 SHALL verify: tx_start pulsed again 3 ticks into a frame with 0x3C -> ignored; first frame bits unchanged; exactly one done.
REQ-032 SHALL verify: tx_start asserted in the done cycle with 0x5A -> second frame's START begins at the next baud_tick; no lost or merged bits.
REQ-033 SHALL verify: rst_n low during DATA bit 4 -> sel=11, busy=0 immediately (asynchronous); no done; next request transmits correctly.
REQ-034 SHALL verify: UART_TX_PARITY_EN undefined, STOP_BITS=2, tx_data=0x81 -> 0,1,0,0,0,0,0,0,1,1,1 with sel never 10; frame length 11 ticks.
